// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of channel streams and the single FIFO write stream that the
// round-robin write arbiter sits between.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned ID_W = $clog2(N_CH);

    logic [N_CH*DATA_W-1:0] ch_tdata;
    logic [N_CH-1:0]        ch_tvalid;
    logic [N_CH-1:0]        ch_tready;
    logic [DATA_W-1:0]      m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [ID_W-1:0]        m_axis_tid;
    logic                   m_axis_tlast;

    // Environment side: sources and FIFO.
    modport master (
        output ch_tdata, ch_tvalid, m_axis_tready,
        input  ch_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast
    );

    // Arbiter side.
    modport slave (
        input  ch_tdata, ch_tvalid, m_axis_tready,
        output ch_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one channel at a time for bursts of up
// to MAX_BURST beats into the capture FIFO, tagging each beat with its
// source channel. Datapath is purely combinational while a grant is held.
module fifo_wr_arbiter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               s_aclk,
    input  logic               s_aresetn,
    fifo_wr_arbiter_if.slave   axis
);
    localparam int unsigned ID_W  = $clog2(N_CH);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  ID_MAX    = ID_W'(N_CH - 1);

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]  last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             found;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  idx;
    logic             gnt_valid;
    logic [DATA_W-1:0] ch_data [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_data[k] = axis.ch_tdata[k*DATA_W +: DATA_W];
    end

    assign gnt_valid = axis.ch_tvalid[gnt_q];

    // Round-robin search: first valid channel after last_gnt, wrapping back to itself.
    always_comb begin
        found = 1'b0;
        pick  = last_gnt_q;
        idx   = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = ID_W'((32'(last_gnt_q) + i) % N_CH);
            if (!found && axis.ch_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state: grant on IDLE, count beats and release on last beat or dropped valid.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            default: begin
                if (!gnt_valid) begin
                    state_d = IDLE;
                end else if (axis.m_axis_tready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset; channel 0 gets first priority.
    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= ID_MAX;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output mux; reset forces every output low combinationally, even mid-burst.
    always_comb begin
        axis.m_axis_tdata  = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.ch_tready     = '0;
        axis.m_axis_tid    = '0;
        axis.m_axis_tlast  = 1'b0;
        if (s_aresetn) begin
            axis.m_axis_tid   = gnt_q;
            axis.m_axis_tdata = ch_data[gnt_q];
            if (state_q == BURST) begin
                axis.m_axis_tvalid    = gnt_valid;
                axis.ch_tready[gnt_q] = axis.m_axis_tready;
                axis.m_axis_tlast     = gnt_valid && (beat_cnt_q == BEAT_LAST);
            end
        end
    end
endmodule
